// File: rtl/baseband_demod.sv
// Subcarrier baseband demodulator: synchronises LANES received lanes and the reference
// subcarrier, counts per-lane agreement over each symbol and majority-decides the bit.
module baseband_demod #(
    parameter int LANES         = 20,
    parameter int SPS           = 32,
    parameter int CNT_W         = 6,
    parameter int FRAME_SYMBOLS = 16,
    parameter int IDX_W         = 5,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic             start,
    input  logic             subcarrier_ref,
    input  logic [LANES-1:0] rx_signal,
    output logic [LANES-1:0] rx_bits,
    output logic             rx_valid,
    output logic             frame_done,
    output logic             busy,
    output logic [IDX_W-1:0] symbol_index
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2
    } state_t;

    localparam int                SET_W       = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SPS - 1);
    localparam logic [CNT_W:0]    SPS_CMP     = (CNT_W + 1)'(SPS);
    localparam logic [IDX_W-1:0]  SYM_LAST    = IDX_W'(FRAME_SYMBOLS - 1);

    logic [LANES-1:0] rx_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ref_sync_q;

    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] acc_q [LANES];
    logic [CNT_W-1:0] acc_d [LANES];
    logic [CNT_W-1:0] acc_total_s [LANES];
    logic [LANES-1:0] bits_q, bits_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             start_prev_q;

    logic [LANES-1:0] agree_s;
    logic [LANES-1:0] decide_s;
    logic             start_accept_s;

    // Equal-depth synchroniser chains keep data and reference phase-aligned.
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                rx_sync_q[s] <= '0;
            end
            ref_sync_q <= '0;
        end else begin
            rx_sync_q[0]  <= rx_signal;
            ref_sync_q[0] <= subcarrier_ref;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                rx_sync_q[s]  <= rx_sync_q[s-1];
                ref_sync_q[s] <= ref_sync_q[s-1];
            end
        end
    end

    assign agree_s = ~(rx_sync_q[SYNC_STAGES-1] ^ {LANES{ref_sync_q[SYNC_STAGES-1]}});

    // Running totals including the current sample; a tie at SPS/2 decides 0.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            acc_total_s[i] = acc_q[i] + {{(CNT_W-1){1'b0}}, agree_s[i]};
            decide_s[i]    = ({acc_total_s[i], 1'b0} > SPS_CMP);
        end
    end

    // A held start or one arriving alongside frame_done must not launch a frame.
    assign start_accept_s = start & ~start_prev_q & ~done_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sample_d = sample_q;
        idx_d    = idx_q;
        bits_d   = bits_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start_accept_s) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_ACCUM;
                    sample_d = '0;
                    idx_d    = '0;
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = '0;
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_ACCUM: begin
                if (sample_q == SAMPLE_LAST) begin
                    bits_d   = decide_s;
                    valid_d  = 1'b1;
                    sample_d = '0;
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = '0;
                    end
                    if (idx_q == SYM_LAST) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    sample_d = sample_q + CNT_W'(1);
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = acc_total_s[i];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, accumulators and registered outputs.
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            sample_q     <= '0;
            idx_q        <= '0;
            bits_q       <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            sample_q     <= sample_d;
            idx_q        <= idx_d;
            bits_q       <= bits_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            start_prev_q <= start;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign rx_bits      = bits_q;
    assign rx_valid     = valid_q;
    assign frame_done   = done_q;
    assign busy         = busy_q;
    assign symbol_index = idx_q;

endmodule

// File: tb/tb_baseband_demod.sv
// Directed bench for baseband_demod: drives XNOR-modulated lanes against a period-4
// subcarrier and checks framing, timing and majority decisions cycle by cycle.
module tb_baseband_demod;

    logic        input_clock;
    logic        reset;
    logic        start;
    logic        subcarrier_ref;
    logic [19:0] rx_signal;
    logic [19:0] rx_bits;
    logic        rx_valid;
    logic        frame_done;
    logic        busy;
    logic [4:0]  symbol_index;

    int n_vec;
    int n_err;
    int ref_ph;

    baseband_demod dut (
        .input_clock  (input_clock),
        .reset        (reset),
        .start        (start),
        .subcarrier_ref(subcarrier_ref),
        .rx_signal    (rx_signal),
        .rx_bits      (rx_bits),
        .rx_valid     (rx_valid),
        .frame_done   (frame_done),
        .busy         (busy),
        .symbol_index (symbol_index)
    );

    initial input_clock = 1'b0;
    always #5 input_clock = ~input_clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Decided bits expected for symbol s in each stimulus mode.
    function automatic logic [19:0] sym_bits(input int mode, input int s);
        logic [31:0] sv;
        sv = 32'(s);
        case (mode)
            0:       sym_bits = 20'hFFFFF;
            1:       sym_bits = 20'h00000;
            2:       sym_bits = 20'hA5A5A;
            3:       sym_bits = 20'h00001;
            4:       sym_bits = {16'h0000, sv[3:0]};
            default: sym_bits = 20'h00000;
        endcase
    endfunction

    // Per-sample data bit driven on each lane (mode 3 varies within the symbol).
    function automatic logic [19:0] sample_data(input int mode, input int s, input int jj);
        if (mode == 3) begin
            sample_data = {17'h00000, (jj < 15), (jj < 16), (jj < 17)};
        end else begin
            sample_data = sym_bits(mode, s);
        end
    endfunction

    // Runs one frame from start. k counts edges after the accepting edge T.
    task automatic run_frame(input int mode, input bit mid_start, input int rst_at);
        logic [19:0] d;
        logic        exp_valid;
        int          s;
        for (int k = 0; k <= 520; k++) begin
            start = (k == 0) || (mid_start && k == 167);
            ref_ph++;
            subcarrier_ref = ref_ph[1];
            d = (k >= 1) ? sample_data(mode, (k - 1) / 32, (k - 1) % 32) : 20'h00000;
            rx_signal = ~(d ^ {20{subcarrier_ref}});
            @(posedge input_clock);
            #1;
            start = 1'b0;
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                check_vec("rst_bits", 32'(rx_bits), 32'h0);
                check_vec("rst_valid", 32'(rx_valid), 32'h0);
                check_vec("rst_done", 32'(frame_done), 32'h0);
                check_vec("rst_busy", 32'(busy), 32'h0);
                check_vec("rst_index", 32'(symbol_index), 32'h0);
                repeat (2) @(posedge input_clock);
                #1;
                reset = 1'b0;
                for (int q = 0; q < 600; q++) begin
                    @(posedge input_clock);
                    #1;
                    check_vec("post_rst_quiet", {29'h0, rx_valid, frame_done, busy}, 32'h0);
                end
                return;
            end
            exp_valid = (k >= 34) && ((k - 34) % 32 == 0) && ((k - 34) / 32 < 16);
            check_vec("rx_valid", 32'(rx_valid), 32'(exp_valid));
            check_vec("frame_done", 32'(frame_done), 32'(k == 514));
            check_vec("busy", 32'(busy), 32'(k < 514));
            if (exp_valid) begin
                s = (k - 34) / 32;
                check_vec("rx_bits", 32'(rx_bits), 32'(sym_bits(mode, s)));
                check_vec("sym_index", 32'(symbol_index), (s == 15) ? 32'd0 : 32'(s + 1));
            end
        end
        check_vec("idle_index", 32'(symbol_index), 32'h0);
        check_vec("held_bits", 32'(rx_bits), 32'(sym_bits(mode, 15)));
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        ref_ph         = 0;
        reset          = 1'b1;
        start          = 1'b0;
        subcarrier_ref = 1'b0;
        rx_signal      = 20'h00000;
        repeat (3) @(posedge input_clock);
        #1;
        check_vec("reset_state", {rx_bits, rx_valid, frame_done, busy, symbol_index}, 32'h0);
        reset = 1'b0;
        @(posedge input_clock);
        #1;

        run_frame(0, 1'b0, -1);
        run_frame(1, 1'b0, -1);
        run_frame(2, 1'b0, -1);
        run_frame(3, 1'b0, -1);
        run_frame(4, 1'b0, -1);
        run_frame(4, 1'b1, -1);
        run_frame(4, 1'b0, 237);
        run_frame(0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
